// File: rtl/conv2d_pkg.sv
// ---------------------------------------------------------------------------
// conv2d_pkg: shared FSM state, accumulator sizing, clamp and default kernel
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package conv2d_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MAC  = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic int acc_width(input int pix_w, input int coef_w, input int k);
    return pix_w + coef_w + $clog2(k * k) + 1;
  endfunction

  function automatic logic [63:0] clamp_pix(input logic signed [63:0] res, input int pix_w);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< pix_w) - 64'sd1;
    if (res < 64'sd0) return '0;
    if (res > max_v) return max_v;
    return res;
  endfunction

  // Identity kernel: only the centre tap is non-zero, at unity gain after SHIFT.
  function automatic logic [31:0] default_coef(input int idx, input int k, input int shift);
    return (idx == (k * k - 1) / 2) ? (32'd1 << shift) : 32'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv2d_mac.sv
// ---------------------------------------------------------------------------
// conv2d_mac: signed multiply-accumulate with tap-0 load, shift and clamp
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv2d_mac
  import conv2d_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 9,
  parameter int K      = 3,
  parameter int SHIFT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     first_i,
  input  logic [PIX_W-1:0]         pix_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic [PIX_W-1:0]         data_o
);

  localparam int ACC_W = acc_width(PIX_W, COEF_W, K);

  logic signed [ACC_W-1:0] pix_s;
  logic signed [ACC_W-1:0] coef_s;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] res;
  logic [PIX_W-1:0]        data_d;
  logic [PIX_W-1:0]        data_q;

  assign pix_s  = {{(ACC_W-PIX_W){1'b0}}, pix_i};
  assign coef_s = {{(ACC_W-COEF_W){coef_i[COEF_W-1]}}, coef_i};
  assign prod   = pix_s * coef_s;
  assign acc_d  = first_i ? prod : acc_q + prod;
  assign res    = acc_d >>> SHIFT;
  // The clamped result tracks every tap, so it is final right after the last one.
  assign data_d = PIX_W'(clamp_pix(64'(res), PIX_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      data_q <= '0;
    end else if (en_i) begin
      acc_q  <= acc_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/conv2d_engine.sv
// ---------------------------------------------------------------------------
// conv2d_engine: streamed K x K convolution; CONV_SAME_PAD_EN selects "same" mode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv2d_engine
  import conv2d_pkg::*;
#(
  parameter int IMG_W  = 9,
  parameter int IMG_H  = 9,
  parameter int K      = 3,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 9,
  parameter int SHIFT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      coef_we_i,
  input  logic [$clog2(K*K)-1:0]    coef_addr_i,
  input  logic [COEF_W-1:0]         coef_data_i,
  input  logic                      start_i,
  input  logic                      pix_valid_i,
  output logic                      pix_ready_o,
  input  logic [PIX_W-1:0]          pix_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [PIX_W-1:0]          out_data_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int TAPS = K * K;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(TAPS);
  localparam int PW   = $clog2(NPIX);
  localparam int CW   = $clog2((IMG_W > IMG_H ? IMG_W : IMG_H) + K) + 1;
`ifdef CONV_SAME_PAD_EN
  localparam int R_LAST = IMG_H - 1;
  localparam int C_LAST = IMG_W - 1;
`else
  localparam int R_LAST = IMG_H - K;
  localparam int C_LAST = IMG_W - K;
`endif

  state_t                   state_q;
  logic                     busy_q;
  logic                     pix_ready_q;
  logic                     out_valid_q;
  logic                     done_q;
  logic [PW-1:0]            ld_q;
  logic [AW-1:0]            tap_q;
  logic [CW-1:0]            ti_q;
  logic [CW-1:0]            tj_q;
  logic [CW-1:0]            r_q;
  logic [CW-1:0]            c_q;
  logic [PIX_W-1:0]         frame_q [NPIX];
  logic signed [COEF_W-1:0] coef_q  [TAPS];

  logic [PW-1:0]            rd_addr;
  logic [PIX_W-1:0]         tap_pix;

`ifdef CONV_SAME_PAD_EN
  localparam logic signed [CW-1:0] PAD_S = CW'((K - 1) / 2);
  localparam logic signed [CW-1:0] H_S   = CW'(IMG_H);
  localparam logic signed [CW-1:0] W_S   = CW'(IMG_W);
  logic signed [CW-1:0] row;
  logic signed [CW-1:0] col;
  logic                 in_frame;

  // Window is centred on (r,c); taps past the border read as zero.
  assign row      = signed'(r_q + ti_q) - PAD_S;
  assign col      = signed'(c_q + tj_q) - PAD_S;
  assign in_frame = (row >= 0) && (row < H_S) && (col >= 0) && (col < W_S);
  assign rd_addr  = PW'(32'(row) * IMG_W + 32'(col));
  assign tap_pix  = in_frame ? frame_q[rd_addr] : '0;
`else
  logic [CW-1:0] row;
  logic [CW-1:0] col;

  assign row     = r_q + ti_q;
  assign col     = c_q + tj_q;
  assign rd_addr = PW'(32'(row) * IMG_W + 32'(col));
  assign tap_pix = frame_q[rd_addr];
`endif

  conv2d_mac #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .K      (K),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .en_i    (state_q == S_MAC),
    .first_i (tap_q == '0),
    .pix_i   (tap_pix),
    .coef_i  (coef_q[tap_q]),
    .data_o  (out_data_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      pix_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ld_q        <= '0;
      tap_q       <= '0;
      ti_q        <= '0;
      tj_q        <= '0;
      r_q         <= '0;
      c_q         <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q     <= S_LOAD;
            busy_q      <= 1'b1;
            pix_ready_q <= 1'b1;
            ld_q        <= '0;
            tap_q       <= '0;
            ti_q        <= '0;
            tj_q        <= '0;
            r_q         <= '0;
            c_q         <= '0;
          end
        end
        S_LOAD: begin
          if (pix_valid_i && pix_ready_q) begin
            ld_q <= ld_q + PW'(1);
            if (ld_q == PW'(NPIX - 1)) begin
              pix_ready_q <= 1'b0;
              state_q     <= S_MAC;
            end
          end
        end
        S_MAC: begin
          tap_q <= tap_q + AW'(1);
          if (tj_q == CW'(K - 1)) begin
            tj_q <= '0;
            ti_q <= ti_q + CW'(1);
          end else begin
            tj_q <= tj_q + CW'(1);
          end
          if (tap_q == AW'(TAPS - 1)) begin
            tap_q       <= '0;
            ti_q        <= '0;
            tj_q        <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (r_q == CW'(R_LAST) && c_q == CW'(C_LAST)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_MAC;
              if (c_q == CW'(C_LAST)) begin
                c_q <= '0;
                r_q <= r_q + CW'(1);
              end else begin
                c_q <= c_q + CW'(1);
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && pix_valid_i && pix_ready_q) begin
      frame_q[ld_q] <= pix_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= COEF_W'(default_coef(i, K, SHIFT));
      end
    end else if (state_q == S_IDLE && coef_we_i && coef_addr_i < AW'(TAPS)) begin
      coef_q[coef_addr_i] <= coef_data_i;
    end
  end

  assign pix_ready_o = pix_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv2d_engine.sv
// ---------------------------------------------------------------------------
// tb_conv2d_engine: table-driven and randomised bench against a window-sum model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_conv2d_engine;

  localparam int IMG_W  = 9;
  localparam int IMG_H  = 9;
  localparam int K      = 3;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 9;
  localparam int SHIFT  = 4;
  localparam int TAPS   = K * K;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int AW     = $clog2(TAPS);
`ifdef CONV_SAME_PAD_EN
  localparam int OFF    = (K - 1) / 2;
  localparam int OUT_H  = IMG_H;
  localparam int OUT_W  = IMG_W;
`else
  localparam int OFF    = 0;
  localparam int OUT_H  = IMG_H - K + 1;
  localparam int OUT_W  = IMG_W - K + 1;
`endif
  localparam int NOUT   = OUT_H * OUT_W;
  localparam int BUDGET = 30000;

  localparam int KN_DEFAULT = 0, KN_IDENT = 1, KN_GAUSS = 2, KN_255 = 3,
                 KN_NEG = 4, KN_ONES = 5, KN_RAND = 6;
  localparam int IM_RAMP = 0, IM_100 = 1, IM_255 = 2, IM_50 = 3, IM_ONES = 4, IM_RAND = 5;
  localparam int RD_ALWAYS = 0, RD_STALL = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              start = 1'b0;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PIX_W-1:0]  out_data;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  conv2d_engine #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .K (K),
    .PIX_W (PIX_W), .COEF_W (COEF_W), .SHIFT (SHIFT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coef_we_i   (coef_we),
    .coef_addr_i (coef_addr),
    .coef_data_i (coef_data),
    .start_i     (start),
    .pix_valid_i (pix_valid),
    .pix_ready_o (pix_ready),
    .pix_data_i  (pix_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy),
    .done_o      (done)
  );

  typedef struct {
    string name;
    int    kn;
    int    im;
    int    rd;
    int    i0; int e0;
    int    i1; int e1;
    int    i2; int e2;
  } vec_t;

  vec_t vecs[7];
  int   n_pass  = 0;
  int   n_total = 0;
  int   kern[TAPS];
  int   img[NPIX];
  int   expv[NOUT];
  int   got[$];

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Straight window sum over the frame, border taps dropped in "same" mode.
  function automatic int model(input int r, input int c);
    int s;
    int y;
    int x;
    s = 0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        y = r + i - OFF;
        x = c + j - OFF;
        if (y >= 0 && y < IMG_H && x >= 0 && x < IMG_W)
          s += kern[i*K+j] * img[y*IMG_W+x];
      end
    end
    s = s >>> SHIFT;
    if (s < 0) return 0;
    if (s > (1 << PIX_W) - 1) return (1 << PIX_W) - 1;
    return s;
  endfunction

  function automatic int got_at(input int i);
    return (i < got.size()) ? got[i] : -1;
  endfunction

  task automatic write_coef(input int a, input int d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = COEF_W'(d);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic set_kernel(input int kn);
    for (int t = 0; t < TAPS; t++) begin
      case (kn)
        KN_GAUSS: kern[t] = (t == TAPS / 2) ? 6 : ((t % 2 == 1) ? 1 : 2);
        KN_255:   kern[t] = 255;
        KN_NEG:   kern[t] = (t == TAPS / 2) ? -16 : 0;
        KN_ONES:  kern[t] = 16;
        KN_RAND:  kern[t] = int'($urandom_range(0, 23)) - 8;
        default:  kern[t] = (t == TAPS / 2) ? (1 << SHIFT) : 0;
      endcase
    end
    if (kn != KN_DEFAULT)
      for (int t = 0; t < TAPS; t++) write_coef(t, kern[t]);
  endtask

  task automatic set_image(input int im);
    for (int p = 0; p < NPIX; p++) begin
      case (im)
        IM_RAMP: img[p] = p;
        IM_100:  img[p] = 100;
        IM_255:  img[p] = 255;
        IM_50:   img[p] = 50;
        IM_ONES: img[p] = 1;
        default: img[p] = int'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic run_frame(input string tag, input int rd_mode, input int abort_at);
    int   sent;
    int   cyc;
    int   stall_left;
    int   hold_viol;
    int   done_cnt;
    int   abort_wait;
    bit   finished;
    bit   aborted;
    bit   prev_stall;
    bit   rdy;
    bit   v;
    logic [PIX_W-1:0] prev_data;

    sent = 0; cyc = 0; stall_left = 0; hold_viol = 0; done_cnt = 0; abort_wait = 0;
    finished = 1'b0; aborted = 1'b0; prev_stall = 1'b0; prev_data = '0;
    got.delete();
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++) expv[r*OUT_W+c] = model(r, c);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_pix_ready"}, pix_ready, 1);

    while (cyc < BUDGET) begin
      if (done) begin
        done_cnt++;
        finished = 1'b1;
        break;
      end
      if (prev_stall && !(out_valid && out_data == prev_data)) hold_viol++;

      v = (sent < NPIX) && ($urandom_range(0, 3) != 0);
      pix_valid = v;
      pix_data  = v ? PIX_W'(img[sent]) : '0;
      if (v && pix_ready) sent++;

      if (rd_mode == RD_ALWAYS) rdy = 1'b1;
      else if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
      else if ($urandom_range(0, 7) == 0) begin rdy = 1'b0; stall_left = 19; end
      else rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (out_valid && rdy) got.push_back(int'(out_data));
      prev_stall = out_valid && !rdy;
      prev_data  = out_data;

      // Writes and restarts while busy must have no effect.
      coef_we   = 1'b1;
      coef_addr = AW'(TAPS / 2);
      coef_data = '0;
      start     = ($urandom_range(0, 7) == 0);

      if (abort_at >= 0 && got.size() == abort_at) begin
        abort_wait++;
        if (abort_wait == 4) begin
          rst = 1'b1;
          #1;
          check({tag, "_rst_pix_ready"}, pix_ready, 0);
          check({tag, "_rst_out_valid"}, out_valid, 0);
          check({tag, "_rst_out_data"}, out_data, 0);
          check({tag, "_rst_busy"}, busy, 0);
          check({tag, "_rst_done"}, done, 0);
          aborted = 1'b1;
          break;
        end
      end
      @(negedge clk);
      cyc++;
    end

    coef_we = 1'b0; start = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
    end else begin
      check({tag, "_finished_in_budget"}, finished, 1);
      @(negedge clk);
      if (done) done_cnt++;
      check({tag, "_idle_after_done"}, busy, 0);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_out_count"}, got.size(), NOUT);
      if (rd_mode == RD_STALL) check({tag, "_stall_hold"}, hold_viol, 0);
    end
    for (int k = 0; k < got.size() && k < NOUT; k++)
      check($sformatf("%s_out%0d", tag, k), got[k], expv[k]);
  endtask

  task automatic apply_vec(input vec_t v, input int abort_at);
    set_kernel(v.kn);
    set_image(v.im);
    run_frame(v.name, v.rd, abort_at);
    if (abort_at < 0) begin
      if (v.i0 >= 0) check($sformatf("%s_probe%0d", v.name, v.i0), got_at(v.i0), v.e0);
      if (v.i1 >= 0) check($sformatf("%s_probe%0d", v.name, v.i1), got_at(v.i1), v.e1);
      if (v.i2 >= 0) check($sformatf("%s_probe%0d", v.name, v.i2), got_at(v.i2), v.e2);
    end
  endtask

  initial begin
    vec_t after_rst;
    vec_t abort_v;
`ifdef CONV_SAME_PAD_EN
    vecs[0] = '{"ident_ramp",  KN_DEFAULT, IM_RAMP, RD_ALWAYS, 0, 0,   1, 1,   80, 80};
    vecs[1] = '{"gauss_100",   KN_GAUSS,   IM_100,  RD_ALWAYS, 10, 112, 40, 112, 0, 62};
    vecs[2] = '{"sat_255",     KN_255,     IM_255,  RD_ALWAYS, 0, 255, 40, 255, 80, 255};
    vecs[3] = '{"neg_50",      KN_NEG,     IM_50,   RD_ALWAYS, 0, 0,   40, 0,   80, 0};
    vecs[4] = '{"ones16",      KN_ONES,    IM_ONES, RD_ALWAYS, 0, 4,   1, 6,    10, 9};
    vecs[5] = '{"rand_stall",  KN_RAND,    IM_RAND, RD_STALL,  -1, 0,  -1, 0,   -1, 0};
    vecs[6] = '{"ident_stall", KN_IDENT,   IM_RAMP, RD_STALL,  0, 0,   1, 1,    80, 80};
    after_rst = '{"post_rst",  KN_DEFAULT, IM_RAMP, RD_ALWAYS, 0, 0,   1, 1,    80, 80};
`else
    vecs[0] = '{"ident_ramp",  KN_DEFAULT, IM_RAMP, RD_ALWAYS, 0, 10,  1, 11,  48, 70};
    vecs[1] = '{"gauss_100",   KN_GAUSS,   IM_100,  RD_ALWAYS, 0, 112, 24, 112, 48, 112};
    vecs[2] = '{"sat_255",     KN_255,     IM_255,  RD_ALWAYS, 0, 255, 24, 255, 48, 255};
    vecs[3] = '{"neg_50",      KN_NEG,     IM_50,   RD_ALWAYS, 0, 0,   24, 0,   48, 0};
    vecs[4] = '{"ones16",      KN_ONES,    IM_ONES, RD_ALWAYS, 0, 9,   24, 9,   48, 9};
    vecs[5] = '{"rand_stall",  KN_RAND,    IM_RAND, RD_STALL,  -1, 0,  -1, 0,   -1, 0};
    vecs[6] = '{"ident_stall", KN_IDENT,   IM_RAMP, RD_STALL,  0, 10,  1, 11,   48, 70};
    after_rst = '{"post_rst",  KN_DEFAULT, IM_RAMP, RD_ALWAYS, 0, 10,  1, 11,   48, 70};
`endif
    abort_v = '{"abort", KN_GAUSS, IM_RAMP, RD_ALWAYS, -1, 0, -1, 0, -1, 0};

    repeat (3) @(negedge clk);
    check("reset_pix_ready", pix_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    for (int n = 0; n < 7; n++) apply_vec(vecs[n], -1);

    apply_vec(abort_v, 10);
    apply_vec(after_rst, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv2d_engine.md
# conv2d_engine

Parametrised 2-D convolution engine for the image-filter datapath. It convolves a streamed greyscale frame with a run-time-programmable signed K×K kernel using one multiply-accumulate per cycle. Each result is normalised by an arithmetic right shift, clamped to the pixel range and emitted on a valid/ready stream in raster order. It generalises the fixed 9×9, 3×3 Gaussian block: image size, kernel size, pixel and coefficient widths are parameters, and the kernel is writable.

## Interface
- IMG_W, 9, frame width in pixels (≥ K)
- IMG_H, 9, frame height in pixels (≥ K)
- K, 3, kernel side; odd, ≥ 3
- PIX_W, 8, unsigned pixel width
- COEF_W, 9, signed coefficient width
- SHIFT, 4, normalisation right-shift
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset: asynchronous, active-high
- coef_we  in  1  coefficient write strobe; honoured only in IDLE
- coef_addr  in  clog2(K*K)  tap index, row-major (row*K+col)
- coef_data  in  COEF_W  signed coefficient
- start  in  1  begin a frame; honoured only in IDLE
- pix_valid / pix_ready  in / out  1  input pixel handshake
- pix_data  in  PIX_W  pixel, raster order
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  PIX_W  clamped result
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last result is accepted

## Operation
- FSM states: IDLE → LOAD (on start) → MAC → EMIT → MAC … → DONE → IDLE.
- IDLE: coef_we writes coef[coef_addr]. A coef_addr ≥ K*K is ignored. coef_we outside IDLE is ignored.
- LOAD: pix_ready=1. Each pix_valid&pix_ready beat stores one pixel into the IMG_W×IMG_H frame buffer. After IMG_W*IMG_H beats the FSM goes to MAC.
- MAC: one tap per cycle, acc += coef[i][j] * img[r+i][c+j], for i,j over 0..K-1. Tap (0,0) loads acc instead of accumulating. After K*K taps the FSM goes to EMIT.
- EMIT: out_valid=1 and out_data is held stable until out_ready. On acceptance the window advances by column, then by row. The last window goes to DONE.
- Valid mode: windows r ∈ [0, IMG_H-K], c ∈ [0, IMG_W-K]. That gives (IMG_H-K+1)(IMG_W-K+1) outputs.
- Arithmetic:
  - ACC_W = PIX_W + COEF_W + clog2(K*K) + 1, signed.
  - Pixels are zero-extended to signed before multiplying.
  - res = acc >>> SHIFT.
  - out_data = 0 if res < 0; 2^PIX_W-1 if res > 2^PIX_W-1; otherwise res[PIX_W-1:0].
- DONE: done=1 for one cycle, then IDLE.
- start asserted while busy is ignored.
- rst mid-frame aborts the frame: FSM to IDLE, outputs to reset values, coefficients reloaded to defaults.

## Timing
- Reset values: pix_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- Default kernel on reset: identity, i.e. centre tap = 2^SHIFT, all other taps 0.
- A start seen in IDLE gives busy=1 and pix_ready=1 on the next cycle.
- Per result: K*K MAC cycles, then out_valid rises on the following cycle. Minimum period is K*K+1 cycles with out_ready held high.
- out_ready held low stalls the engine indefinitely with no data loss.
- done rises the cycle after the final out_valid&out_ready beat.
- A coefficient write is visible to the next frame. Writes take effect the cycle after coef_we.

## Configuration
- CONV_SAME_PAD_EN defined: "same" mode.
  - IMG_H×IMG_W outputs; window centre runs over every pixel.
  - Taps that fall outside the frame contribute 0; the buffer is not read for them.
  - The window origin is offset by -(K-1)/2.
- CONV_SAME_PAD_EN undefined: valid mode only; no padding logic.

## Structure
- Package conv2d_pkg holds:
  - the FSM state enum;
  - the ACC_W computation;
  - the clamp function;
  - the default-kernel constant function.
- Sub-module conv2d_mac: signed multiply, accumulate with load, shift and clamp. Its inputs are pixel, coef, first-tap flag and enable.
- Top level owns the FSM, the window/tap counters, the frame buffer and the coefficient file.

## Test plan
- Reset kernel (identity), 9×9 ramp p=r*9+c, valid mode → 49 outputs; first 10, second 11, last 70; done pulses once.
- Kernel 2,1,2/1,6,1/2,1,2, SHIFT=4, constant image 100 → every output 1800>>4 = 112.
- All coefs 255, all pixels 255 → every output clamps to 255. Centre tap -16, others 0, pixels 50 → -50 clamps to 0.
- Randomised out_ready with 20-cycle low stretches → out_data stable while stalled, 49 results match the model, no duplicates or drops.
- rst pulsed mid-MAC on result 10 → outputs return to reset values at once, identity kernel restored, a new start gives correct first result 10.
- CONV_SAME_PAD_EN, all-ones kernel, SHIFT=0, image of ones → 81 outputs: corners 4, edges 6, interior 9.
